sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares the single-port 4096x8 image SRAM among N requesters: loader write, display read, and filter-window read.
- Round-robin arbitration with optional burst lock and a forced-release limit.
- Returns read data one cycle after grant and tags it to the owner.
- Sits between the engine's op-level sequencing and the SRAM macro, replacing per-state address muxing.

Parameters:
- N_REQ, 3, number of requesters (index 0 = loader, 1 = display, 2 = filter).
- AW, 12, SRAM address width.
- DW, 8, SRAM data width.
- MAX_BURST, 16, max consecutive grants to one locked owner before forced release (>=1).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_req  in  N_REQ  per-requester access request.
- i_lock  in  N_REQ  per-requester burst lock; only meaningful together with i_req.
- i_we  in  N_REQ  1 = write, 0 = read.
- i_addr  in  N_REQ*AW  flattened addresses; requester k occupies bits [k*AW +: AW].
- i_wdata  in  N_REQ*DW  flattened write data.
- o_gnt  out  N_REQ  one-hot grant, combinational; the access completes this cycle.
- o_rvalid  out  N_REQ  one-hot read-return strobe, registered.
- o_rdata  out  DW  read data; qualified only by o_rvalid.
- o_sram_cen  out  1  chip enable, active low; low only when some grant is active.
- o_sram_wen  out  1  write enable, active low.
- o_sram_a  out  AW  SRAM address.
- o_sram_d  out  DW  SRAM write data.
- i_sram_q  in  DW  SRAM read data, valid one cycle after address.

Behaviour:
- Reset (i_rst_n low at posedge):
  - FSM = ARB; rr_ptr = 0; owner = 0; burst_cnt = 0.
  - o_rvalid = 0.
  - While reset is asserted, o_gnt = 0 and o_sram_cen = 1 regardless of i_req.
- Reset mid-burst drops the lock. A read granted in the cycle before reset is asserted gets no o_rvalid.
- FSM states: ARB, OWN.
- ARB:
  - Winner = first k with i_req[k], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - o_gnt = onehot(winner) in the same cycle. No request means o_gnt = 0 and cen = 1.
  - On grant: rr_ptr <= winner+1 mod N_REQ (wraps at N_REQ-1 -> 0).
  - If i_lock[winner]: owner <= winner, burst_cnt <= 1, go to OWN.
- OWN:
  - Only owner can be granted; all others see o_gnt = 0.
  - Grant when i_req[owner]; burst_cnt increments per grant.
  - Return to ARB next cycle when any of these holds:
    - i_lock[owner] = 0, or
    - i_req[owner] = 0 (no grant that cycle), or
    - a grant makes burst_cnt reach MAX_BURST (that grant is still honoured; this is the forced release).
  - After forced release, rr_ptr = owner+1, so another pending requester wins next, even if the owner keeps lock asserted.
- MAX_BURST = 1 means lock never extends past a single grant.
- SRAM drive:
  - o_sram_a, o_sram_d, o_sram_wen = ~i_we are muxed from the granted requester.
  - With no grant: a = 0, d = 0, wen = 1.
- Read return: o_rvalid[k] <= o_gnt[k] & ~i_we[k] (registered); o_rdata = i_sram_q, passed through combinationally.
- Latency: a read granted in cycle t is returned in cycle t+1.
- Pipelining: back-to-back reads from different requesters are allowed, one per cycle.
- Write then read to the same address in consecutive cycles returns the new data (the macro is write-first).
- Starvation bound: any continuously requesting k is granted within (N_REQ-1)*MAX_BURST + N_REQ cycles.
- Throughput: one access per cycle maximum; no idle cycle is inserted between ARB and OWN.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- When defined, add ports:
  - o_gnt_cnt (out, N_REQ*16): per-requester saturating grant counters.
  - o_stall_cnt (out, 16): saturating count of cycles where some i_req bit was set but not granted.
  - i_stats_clr (in, 1): synchronous clear.
- All counters reset to 0 and saturate at 16'hFFFF.
- If i_stats_clr is asserted in the same cycle as a grant, the counter becomes 0.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package: requester index constants (REQ_LOAD = 0, REQ_DISP = 1, REQ_FILT = 2) and the FSM state encoding (ARB = 1'b0, OWN = 1'b1).
- Sub-module rr_pick: combinational round-robin priority picker (inputs: req vector, rr_ptr; outputs: one-hot grant, index).

Test Plan:
- Reset then i_req = 3'b111, no lock, for 6 cycles -> o_gnt sequence 001, 010, 100, 001, 010, 100; o_sram_cen = 0 in every cycle.
- Req 1 reads addr 12'h0A5 with memory[0x0A5] = 8'h3C -> next cycle o_rvalid = 3'b010 and o_rdata = 8'h3C. Req 0 writes 8'h7F to 0x010, then req 2 reads 0x010 the next cycle -> o_rdata = 8'h7F.
- Req 0 requests with lock held for 40 cycles, req 2 requests continuously, MAX_BURST = 16 -> 16 grants to req 0, one to req 2, then 16 to req 0, and so on; req 2 waits no more than 16 cycles.
- Lock owner drops i_req for one cycle while req 1 is pending -> that cycle o_gnt = 0; the next cycle req 1 is granted in ARB.
- i_rst_n low in the middle of an OWN burst with a read granted in the previous cycle -> o_rvalid = 0 after reset; the first grant after reset goes to the lowest-index requester.
- With SRAM_ARB_STATS_EN: 5 grants to req 2, then i_stats_clr together with one more grant -> o_gnt_cnt[2] reads 5 before the clear and 0 after it.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the image-SRAM port arbiter: requester indices and FSM encoding.
// Optional statistics counters are enabled by defining SRAM_ARB_STATS_EN.
package sram_port_arbiter_pkg;

  localparam int REQ_LOAD = 0;
  localparam int REQ_DISP = 1;
  localparam int REQ_FILT = 2;

  typedef enum logic {
    ARB = 1'b0,
    OWN = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N_REQ.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_valid
);

  logic [IW:0]   sum;
  logic [IW-1:0] k;

  // NOTE: every variable gets a default before the search so no path leaves one unassigned (no latch).
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    sum     = '0;
    k       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // ptr < N_REQ and i < N_REQ, so one conditional subtract is a full modulo.
      sum = {1'b0, i_ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      k = sum[IW-1:0];
      if (!o_valid && i_req[k]) begin
        o_valid  = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = k;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among N_REQ requesters, with burst lock.
// Define SRAM_ARB_STATS_EN to add saturating grant/stall counters and their clear input.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int AW        = 12,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ-1:0]    i_lock,
  input  logic [N_REQ-1:0]    i_we,
  input  logic [N_REQ*AW-1:0] i_addr,
  input  logic [N_REQ*DW-1:0] i_wdata,
  output logic [N_REQ-1:0]    o_gnt,
  output logic [N_REQ-1:0]    o_rvalid,
  output logic [DW-1:0]       o_rdata,
  output logic                o_sram_cen,
  output logic                o_sram_wen,
  output logic [AW-1:0]       o_sram_a,
  output logic [DW-1:0]       o_sram_d,
`ifdef SRAM_ARB_STATS_EN
  output logic [N_REQ*16-1:0] o_gnt_cnt,
  output logic [15:0]         o_stall_cnt,
  input  logic                i_stats_clr,
`endif
  input  logic [DW-1:0]       i_sram_q
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [CW-1:0]    burst_cnt_q, burst_cnt_d;
  logic [N_REQ-1:0] rvalid_q, rvalid_d;
  logic [N_REQ-1:0] gnt;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    return (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
  endfunction

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (rr_ptr_q),
    .o_gnt   (pick_gnt),
    .o_idx   (pick_idx),
    .o_valid (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    gnt         = '0;
    unique case (state_q)
      ARB: begin
        if (pick_valid) begin
          gnt      = pick_gnt;
          rr_ptr_d = wrap_inc(pick_idx);
          // With MAX_BURST == 1 the first grant already exhausts the burst.
          if (i_lock[pick_idx] && (MAX_BURST > 1)) begin
            owner_d     = pick_idx;
            burst_cnt_d = CW'(1);
            state_d     = OWN;
          end
        end
      end
      OWN: begin
        if (i_req[owner_q]) begin
          gnt[owner_q] = 1'b1;
          burst_cnt_d  = burst_cnt_q + CW'(1);
          rr_ptr_d     = wrap_inc(owner_q);
          if (!i_lock[owner_q] || (burst_cnt_d >= CW'(MAX_BURST))) state_d = ARB;
        end else begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    if (!i_rst_n) gnt = '0;
  end

  always_comb begin
    o_sram_a   = '0;
    o_sram_d   = '0;
    o_sram_wen = 1'b1;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        o_sram_a   = i_addr[k*AW +: AW];
        o_sram_d   = i_wdata[k*DW +: DW];
        o_sram_wen = ~i_we[k];
      end
    end
  end

  assign rvalid_d   = gnt & ~i_we;
  assign o_gnt      = gnt;
  assign o_sram_cen = ~|gnt;
  assign o_rdata    = i_sram_q;
  // Masked while reset is held so a read granted just before reset never returns.
  assign o_rvalid   = i_rst_n ? rvalid_q : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      rvalid_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid_q    <= rvalid_d;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] gnt_cnt_q [N_REQ];
  logic [15:0] gnt_cnt_d [N_REQ];
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    o_gnt_cnt   = '0;
    stall_cnt_d = stall_cnt_q;
    for (int k = 0; k < N_REQ; k++) begin
      gnt_cnt_d[k] = gnt_cnt_q[k];
      if (i_stats_clr)                               gnt_cnt_d[k] = '0;
      else if (gnt[k] && (gnt_cnt_q[k] != 16'hFFFF)) gnt_cnt_d[k] = gnt_cnt_q[k] + 16'd1;
      o_gnt_cnt[k*16 +: 16] = gnt_cnt_q[k];
    end
    if (i_stats_clr)                                          stall_cnt_d = '0;
    else if ((|i_req) && !(|gnt) && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  assign o_stall_cnt = stall_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      for (int k = 0; k < N_REQ; k++) gnt_cnt_q[k] <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      for (int k = 0; k < N_REQ; k++) gnt_cnt_q[k] <= gnt_cnt_d[k];
    end
  end
`endif

endmodule
